// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: debounce channel state encoding and timing defaults
// used by the key debouncer and the stopwatch control FSM.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    KEY_REL       = 2'd0,
    KEY_PRESS_CHK = 2'd1,
    KEY_PRESSED   = 2'd2,
    KEY_REL_CHK   = 2'd3
  } key_state_t;

  // 40 ms stability window and 1 s long-press at a 100 Hz debounce rate
  localparam int DB_SAMPLES_DEF = 4;
  localparam int LONG_TICKS_DEF = 100;

  // Width of a counter that must hold values 0..maxval inclusive
  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: four-state stability FSM with a hold timer; all state moves
// only on debounce ticks, pulses are registered and last exactly one clk cycle.
module key_debounce_ch
  import stopwatch_pkg::*;
#(
  parameter int DB_SAMPLES = DB_SAMPLES_DEF,
  parameter int LONG_TICKS = LONG_TICKS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic s,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int CW = cnt_width(DB_SAMPLES);
  localparam int HW = cnt_width(LONG_TICKS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DONE  = CW'(DB_SAMPLES);
  localparam logic [HW-1:0] HOLD_DONE = HW'(LONG_TICKS);
  localparam logic          SINGLE    = (DB_SAMPLES == 1);

  key_state_t      state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next, cnt_inc;
  logic [HW-1:0]   hold_reg, hold_next, hold_inc;
  logic            level_reg, level_next;
  logic            press_reg, press_next;
  logic            release_reg, release_next;
  logic            long_reg, long_next;

  assign cnt_inc  = cnt_reg + CW'(1);
  assign hold_inc = hold_reg + HW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= KEY_REL;
      cnt_reg     <= '0;
      hold_reg    <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      long_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      hold_reg    <= hold_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      long_reg    <= long_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hold_next  = hold_reg;
    if (tick) begin
      case (state_reg)
        KEY_REL: begin
          if (s) begin
            if (SINGLE) begin
              state_next = KEY_PRESSED;
              hold_next  = '0;
            end else begin
              state_next = KEY_PRESS_CHK;
              cnt_next   = CNT_ONE;
            end
          end
        end
        KEY_PRESS_CHK: begin
          if (!s) begin
            state_next = KEY_REL;
            cnt_next   = '0;
          end else if (cnt_inc == CNT_DONE) begin
            state_next = KEY_PRESSED;
            cnt_next   = '0;
            hold_next  = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        KEY_PRESSED: begin
          if (s) begin
            // hold saturates so key_long fires only once per press
            if (hold_reg != HOLD_DONE) hold_next = hold_inc;
          end else if (SINGLE) begin
            state_next = KEY_REL;
            hold_next  = '0;
          end else begin
            state_next = KEY_REL_CHK;
            cnt_next   = CNT_ONE;
          end
        end
        KEY_REL_CHK: begin
          if (s) begin
            // glitch: return to PRESSED with hold untouched
            state_next = KEY_PRESSED;
            cnt_next   = '0;
          end else if (cnt_inc == CNT_DONE) begin
            state_next = KEY_REL;
            cnt_next   = '0;
            hold_next  = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = KEY_REL;
          cnt_next   = '0;
          hold_next  = '0;
        end
      endcase
    end
  end

  always_comb begin
    press_next   = 1'b0;
    release_next = 1'b0;
    long_next    = 1'b0;
    if (tick) begin
      case (state_reg)
        KEY_REL:       press_next   = s && SINGLE;
        KEY_PRESS_CHK: press_next   = s && (cnt_inc == CNT_DONE);
        KEY_PRESSED: begin
          long_next    = s && (hold_reg != HOLD_DONE) && (hold_inc == HOLD_DONE);
          release_next = !s && SINGLE;
        end
        KEY_REL_CHK:   release_next = !s && (cnt_inc == CNT_DONE);
        default: begin
          press_next   = 1'b0;
          release_next = 1'b0;
        end
      endcase
    end
    level_next = level_reg;
    if (press_next)   level_next = 1'b1;
    if (release_next) level_next = 1'b0;
  end

  assign level         = level_reg;
  assign press_pulse   = press_reg;
  assign release_pulse = release_reg;
  assign long_pulse    = long_reg;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: synchronises raw keys and the debounce-rate clock into clk,
// derives a one-cycle tick per clk_db rising edge and runs one channel per key.
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int NKEYS      = 3,
  parameter int DB_SAMPLES = DB_SAMPLES_DEF,
  parameter int LONG_TICKS = LONG_TICKS_DEF,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_db,
  input  logic [NKEYS-1:0] key_in,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic [NKEYS-1:0] key_long
);

  localparam logic POL = (ACTIVE_LOW != 0);

  logic [NKEYS-1:0] key_meta_reg, key_sync_reg;
  logic             db_meta_reg, db_sync_reg, db_prev_reg;
  logic             tick;
  logic [NKEYS-1:0] key_s;

  // clk_db is sampled as data; only its synchronised rising edge matters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta_reg <= '0;
      key_sync_reg <= '0;
      db_meta_reg  <= 1'b0;
      db_sync_reg  <= 1'b0;
      db_prev_reg  <= 1'b0;
    end else begin
      key_meta_reg <= key_in;
      key_sync_reg <= key_meta_reg;
      db_meta_reg  <= clk_db;
      db_sync_reg  <= db_meta_reg;
      db_prev_reg  <= db_sync_reg;
    end
  end

  assign tick  = db_sync_reg & ~db_prev_reg;
  assign key_s = key_sync_reg ^ {NKEYS{POL}};

  generate
    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_ch
      key_debounce_ch #(
        .DB_SAMPLES (DB_SAMPLES),
        .LONG_TICKS (LONG_TICKS)
      ) u_ch (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .s             (key_s[gi]),
        .level         (key_level[gi]),
        .press_pulse   (key_press[gi]),
        .release_pulse (key_release[gi]),
        .long_pulse    (key_long[gi])
      );
    end
  endgenerate

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Multi-key debouncer for the stopwatch front panel.
- Consumes the clk_db debounce rate clock from the clock divider as a sampled strobe, entirely within the clk domain.
- Converts raw bouncing push-button inputs into clean levels plus one-cycle press, release and long-press pulses.
- Feeds the stopwatch control FSM (start/stop, lap, clear).

Parameters:
- NKEYS, 3, number of independent key channels.
- DB_SAMPLES, 4, consecutive equal tick samples required to accept a change; 40 ms at 100 Hz. Must be >= 1.
- LONG_TICKS, 100, ticks of continuous debounced press before key_long fires; 1 s at 100 Hz. Must be >= 1.
- ACTIVE_LOW, 0, 1 = raw key reads 0 when pressed; inversion is applied after synchronisation.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset, asynchronous, active-high.
- clk_db  in  1  debounce rate clock from the divider, treated as data, never used as a clock.
- key_in  in  NKEYS  raw asynchronous button inputs.
- key_level  out  NKEYS  debounced pressed level, 1 = pressed.
- key_press  out  NKEYS  one-clk pulse on accepted press.
- key_release  out  NKEYS  one-clk pulse on accepted release.
- key_long  out  NKEYS  one-clk pulse when a press has been held LONG_TICKS ticks.

Behaviour:
- Reset:
  - All outputs 0.
  - All channels in REL state.
  - All counters 0.
  - Synchroniser flops 0.
  - Edge-detect history 0.
- Synchronisation:
  - key_in and clk_db each pass through a 2-FF synchroniser in clk.
  - Key polarity is normalised after the synchroniser: s = sync ^ ACTIVE_LOW.
- Tick:
  - tick = synced clk_db AND NOT previous synced clk_db. This is one clk cycle per clk_db rising edge.
  - All channel state advances only on tick cycles.
  - With no clk_db edges, all state and levels freeze and no pulses are produced.
- Per-channel FSM (states REL, PRESS_CHK, PRESSED, REL_CHK) and counters:
  - cnt is the stability counter, width $clog2(DB_SAMPLES+1).
  - hold is the hold counter, width $clog2(LONG_TICKS+1).
- Transitions, evaluated on tick only, using s as sampled in that cycle:
  - REL, s=1:
    - If DB_SAMPLES=1: go directly to PRESSED and accept the press.
    - Otherwise: go to PRESS_CHK, cnt=1.
  - REL, s=0: stay in REL.
  - PRESS_CHK, s=1: cnt+1. When the new cnt equals DB_SAMPLES, go to PRESSED and accept the press.
  - PRESS_CHK, s=0: go to REL, cnt=0. No pulse.
  - PRESSED, s=1: hold+1, saturating at LONG_TICKS. On the tick where hold becomes LONG_TICKS, pulse key_long. It fires once per press.
  - PRESSED, s=0: go to REL_CHK, cnt=1 (same DB_SAMPLES=1 shortcut as REL). hold keeps counting only while in PRESSED.
  - REL_CHK, s=0: cnt+1. When the new cnt equals DB_SAMPLES, go to REL and accept the release.
  - REL_CHK, s=1: go back to PRESSED, cnt=0. hold is retained, so a glitch does not restart the long timer and does not re-fire key_long.
- Accept press:
  - key_level goes to 1 and key_press pulses.
  - hold=0.
  - The pulse is asserted in the clk cycle after the accepting tick cycle, for exactly 1 clk cycle.
- Accept release:
  - key_level goes to 0 and key_release pulses.
  - hold=0.
  - Same timing as accept press.
- Latency:
  - Raw edge to pulse = 2 sync cycles, plus the wait for the DB_SAMPLES-th tick, plus 1 clk cycle.
  - Nominal 40 ms at defaults.
- A release following a key_long still produces key_release.
- Channels are fully independent; several pulses may assert in the same cycle.
- A key held through reset deassertion is debounced afresh and yields key_press after DB_SAMPLES ticks.
- Reset asserted mid-operation clears everything immediately, with no pulses.

Decomposition:
- Shared package/header stopwatch_pkg:
  - State encoding constants KEY_REL=2'd0, KEY_PRESS_CHK=2'd1, KEY_PRESSED=2'd2, KEY_REL_CHK=2'd3.
  - Default DB_SAMPLES and LONG_TICKS constants, also used by the control FSM.
- Sub-module key_debounce_ch holds one channel's FSM, counters and output pulse regs.
  - Generate-instantiated NKEYS times.
  - Top level holds the synchronisers and tick detect.

Test Plan:
- Bench setup: clk_db toggles every 5 clk cycles, giving a tick every 10 cycles. Parameters: NKEYS=3, DB_SAMPLES=4, LONG_TICKS=6, ACTIVE_LOW=0.
- Clean press: key_in[0] 0->1 and held -> key_press[0] pulses exactly once, 1 cycle wide, after the 4th tick sampling 1; key_level[0]=1; no other outputs toggle.
- Bounce: key_in[1] toggles 1,0,1,0 across successive ticks, then settles at 1 -> no pulse during the bounce; key_press[1] after 4 stable ticks; one pulse total.
- Long press and glitch: hold key_in[2] -> key_long[2] on the 6th tick after acceptance; a 1-tick 0 glitch afterwards gives no release and no second key_long; a real release gives key_release[2] after 4 ticks at 0.
- Reset mid-check: rst asserted during PRESS_CHK with cnt=2 -> all outputs 0 immediately; key still held after rst -> key_press after 4 fresh ticks.
- Frozen clock, simultaneous keys and polarity:
  - clk_db held constant while key_in changes -> no outputs change.
  - Then restart clk_db with keys 0 and 1 pressed together -> both key_press pulse in the same cycle.
  - Repeat with ACTIVE_LOW=1 and inverted stimulus -> identical outputs.
